// File: rtl/spi_cap_pkg.sv
// +----------------------------------------------------------------------------+
// | spi_cap_pkg                                                                |
// | Shared constants and types for the SPI frame capture block.                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package spi_cap_pkg;

  localparam int FRAME_BITS_DEF = 96;
  localparam int NUM_SLOTS_DEF  = 7;
  localparam int SLOT_W         = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef struct packed {
    logic [SLOT_W-1:0]         slot;
    logic [FRAME_BITS_DEF-1:0] data;
  } frame_entry_t;

endpackage : spi_cap_pkg

`default_nettype wire

// File: rtl/spi_cap_fifo.sv
// +----------------------------------------------------------------------------+
// | spi_cap_fifo                                                               |
// | Synchronous FIFO, registered storage with a combinational head read.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_cap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A simultaneous pop frees the slot the push needs, so full alone does not drop.
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign drop_o    = push_i & ~w_do_push;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule : spi_cap_fifo

`default_nettype wire

// File: rtl/spi_frame_capture.sv
// +----------------------------------------------------------------------------+
// | spi_frame_capture                                                          |
// | Oversamples SPI MOSI into slot-tagged frames queued on a valid/ready port. |
// | Optional macro SPI_CAP_SLOT_CHECK_EN: one-hot slot check and slot_err.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_frame_capture
  import spi_cap_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int NUM_SLOTS  = NUM_SLOTS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  input  logic [NUM_SLOTS-1:0]  slot_sel,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic [SLOT_W-1:0]     frame_slot,
  output logic                  frame_abort,
  output logic                  overflow,
`ifdef SPI_CAP_SLOT_CHECK_EN
  output logic                  slot_err,
`endif
  input  logic                  ovf_clr
);

  localparam int               CNT_W    = $clog2(FRAME_BITS);
  localparam int               ENTRY_W  = SLOT_W + FRAME_BITS;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic                  clk_r0_q;
  logic                  clk_r1_q;
  logic                  mosi_r0_q;
  logic                  mosi_r1_q;
  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [CNT_W-1:0]      bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] shift_d;
  logic                  abort_q;
  logic                  abort_d;
  logic                  overflow_q;

  logic                  w_rise;
  logic                  w_push;
  logic                  w_pop;
  logic [FRAME_BITS-1:0] w_frame;
  logic [SLOT_W-1:0]     w_slot_bin;
  logic [SLOT_W-1:0]     w_slot_tag;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;

  // spi_cs is deliberately left unsynchronised so frame boundaries line up
  // cycle-for-cycle with the slot detector that produces slot_sel.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_r0_q  <= 1'b0;
      clk_r1_q  <= 1'b0;
      mosi_r0_q <= 1'b0;
      mosi_r1_q <= 1'b0;
    end else begin
      clk_r0_q  <= spi_clk;
      clk_r1_q  <= clk_r0_q;
      mosi_r0_q <= spi_mosi;
      mosi_r1_q <= mosi_r0_q;
    end
  end

  assign w_rise  = clk_r0_q & ~clk_r1_q;
  assign w_frame = {shift_q[FRAME_BITS-2:0], mosi_r1_q};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    abort_d   = 1'b0;
    w_push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (!spi_cs) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (spi_cs) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          abort_d   = (bit_cnt_q != '0);
        end else if (w_rise) begin
          shift_d = w_frame;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            w_push    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      abort_q   <= abort_d;
    end
  end

  // Descending scan so the lowest set flag is the last assignment and wins.
  always_comb begin
    w_slot_bin = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_sel[i]) w_slot_bin = SLOT_W'(i + 1);
    end
  end

`ifdef SPI_CAP_SLOT_CHECK_EN
  logic w_slot_bad;
  logic slot_err_q;

  assign w_slot_bad = (slot_sel == '0) ||
                      ((slot_sel & (slot_sel - NUM_SLOTS'(1))) != '0);
  assign w_slot_tag = w_slot_bad ? '0 : w_slot_bin;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_err_q <= 1'b0;
    end else if (w_push && w_slot_bad) begin
      slot_err_q <= 1'b1;
    end else if (ovf_clr) begin
      slot_err_q <= 1'b0;
    end
  end

  assign slot_err = slot_err_q;
`else
  assign w_slot_tag = w_slot_bin;
`endif

  spi_cap_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .push_i  (w_push),
    .wdata_i ({w_slot_tag, w_frame}),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .drop_o  (w_drop)
  );

  // Drop wins over a same-cycle clear so a fresh loss is never hidden.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow_q <= 1'b0;
    end else if (w_drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign frame_valid = ~w_empty;
  assign w_pop       = frame_valid & frame_ready;
  assign frame_data  = frame_valid ? w_head[FRAME_BITS-1:0] : '0;
  assign frame_slot  = frame_valid ? w_head[ENTRY_W-1 -: SLOT_W] : '0;
  assign frame_abort = abort_q;
  assign overflow    = overflow_q;

  logic w_unused;
  assign w_unused = w_full;

endmodule : spi_frame_capture

`default_nettype wire

// File: tb/tb_spi_frame_capture.sv
// +----------------------------------------------------------------------------+
// | tb_spi_frame_capture                                                       |
// | Directed self-checking bench for spi_frame_capture.                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_spi_frame_capture;

  localparam int FB = 96;

  logic          sys_clk     = 1'b0;
  logic          sys_rst_n   = 1'b0;
  logic          spi_clk     = 1'b0;
  logic          spi_cs      = 1'b1;
  logic          spi_mosi    = 1'b0;
  logic [6:0]    slot_sel    = 7'b0;
  logic          frame_ready = 1'b0;
  logic          ovf_clr     = 1'b0;
  logic          frame_valid;
  logic [FB-1:0] frame_data;
  logic [2:0]    frame_slot;
  logic          frame_abort;
  logic          overflow;
`ifdef SPI_CAP_SLOT_CHECK_EN
  logic          slot_err;
`endif

  int checks = 0;
  int errors = 0;

  spi_frame_capture dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .slot_sel    (slot_sel),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_slot  (frame_slot),
    .frame_abort (frame_abort),
    .overflow    (overflow),
`ifdef SPI_CAP_SLOT_CHECK_EN
    .slot_err    (slot_err),
`endif
    .ovf_clr     (ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FB-1:0] pat(input logic [31:0] base, input int k);
    logic [31:0] w;
    w = base + 32'(k);
    return {3{w}};
  endfunction

  // One SPI bit: 2 cycles setup, 3 cycles high, 2 low. The rise strobe edge
  // falls between the 1st and 2nd negedge after spi_clk goes high.
  task automatic spi_bit(input logic b, input bit pop, input bit chk_lat);
    spi_mosi = b;
    repeat (2) @(negedge sys_clk);
    spi_clk = 1'b1;
    @(negedge sys_clk);
    if (chk_lat) check("valid_before_strobe", 128'(frame_valid), 128'd0);
    if (pop) frame_ready = 1'b1;
    @(negedge sys_clk);
    if (pop) frame_ready = 1'b0;
    if (chk_lat) check("valid_after_strobe", 128'(frame_valid), 128'd1);
    @(negedge sys_clk);
    spi_clk = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [FB-1:0] d, input logic [6:0] sel, input int nbits,
                            input bit pop_last, input bit chk_lat);
    slot_sel = sel;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(d[FB-1-i], pop_last && (i == nbits - 1), chk_lat && (i == nbits - 1));
    end
  endtask

  task automatic pop_head(input string tag, input logic [FB-1:0] d, input logic [2:0] slot);
    check({tag, "_valid"}, 128'(frame_valid), 128'd1);
    check({tag, "_data"}, 128'(frame_data), 128'(d));
    check({tag, "_slot"}, 128'(frame_slot), 128'(slot));
    frame_ready = 1'b1;
    @(negedge sys_clk);
    frame_ready = 1'b0;
  endtask

  task automatic pulse_ovf_clr();
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_valid", 128'(frame_valid), 128'd0);
    check("rst_data", 128'(frame_data), 128'd0);
    check("rst_slot", 128'(frame_slot), 128'd0);
    check("rst_abort", 128'(frame_abort), 128'd0);
    check("rst_ovf", 128'(overflow), 128'd0);
    sys_rst_n = 1'b1;
    spi_cs    = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Basic frame with completion latency
    send_frame({12{8'hA5}}, 7'b0000001, FB, 1'b0, 1'b1);
    pop_head("basic", {12{8'hA5}}, 3'd1);
    check("basic_empty", 128'(frame_valid), 128'd0);

    // Back-to-back frames, slots 1..7, no cs toggle
    for (int k = 1; k <= 7; k++) begin
      send_frame(pat(32'h5EED_0000, k), 7'(1 << (k - 1)), FB, 1'b0, 1'b0);
      pop_head($sformatf("b2b%0d", k), pat(32'h5EED_0000, k), 3'(k));
    end

    // Abort after 40 bits, then a clean frame
    send_frame({12{8'hFF}}, 7'b0000001, 40, 1'b0, 1'b0);
    spi_cs = 1'b1;
    @(negedge sys_clk);
    check("abort_pulse", 128'(frame_abort), 128'd1);
    @(negedge sys_clk);
    check("abort_once", 128'(frame_abort), 128'd0);
    check("abort_nopush", 128'(frame_valid), 128'd0);
    spi_cs = 1'b0;
    repeat (3) @(negedge sys_clk);
    send_frame(96'h0123_4567_89AB_CDEF_0F1E_2D3C, 7'b0001000, FB, 1'b0, 1'b0);
    pop_head("post_abort", 96'h0123_4567_89AB_CDEF_0F1E_2D3C, 3'd4);

    // cs rising on a frame boundary must not abort
    spi_cs = 1'b1;
    @(negedge sys_clk);
    check("noabort_a", 128'(frame_abort), 128'd0);
    @(negedge sys_clk);
    check("noabort_b", 128'(frame_abort), 128'd0);
    spi_cs = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Overflow: 5 frames into a 4-deep queue
    for (int k = 0; k < 5; k++) begin
      send_frame(pat(32'hC0DE_0000, k), 7'(1 << k), FB, 1'b0, 1'b0);
      if (k == 3) check("ovf_not_yet", 128'(overflow), 128'd0);
    end
    check("ovf_set", 128'(overflow), 128'd1);
    for (int k = 0; k < 4; k++) begin
      pop_head($sformatf("ovf_drain%0d", k), pat(32'hC0DE_0000, k), 3'(k + 1));
    end
    check("ovf_empty", 128'(frame_valid), 128'd0);
    check("ovf_sticky", 128'(overflow), 128'd1);
    pulse_ovf_clr();
    check("ovf_clr", 128'(overflow), 128'd0);

    // Push into a full queue with a pop in the completion cycle
    for (int k = 0; k < 4; k++) begin
      send_frame(pat(32'hBEEF_0000, k), 7'b0000001, FB, 1'b0, 1'b0);
    end
    send_frame(pat(32'hBEEF_0000, 4), 7'b0000010, FB, 1'b1, 1'b0);
    check("fullpop_ovf", 128'(overflow), 128'd0);
    for (int k = 1; k < 5; k++) begin
      pop_head($sformatf("fullpop%0d", k), pat(32'hBEEF_0000, k), (k == 4) ? 3'd2 : 3'd1);
    end
    check("fullpop_empty", 128'(frame_valid), 128'd0);

    // Multi-hot and all-zero slot flags
    send_frame({12{8'h3C}}, 7'b0000110, FB, 1'b0, 1'b0);
`ifdef SPI_CAP_SLOT_CHECK_EN
    check("slot_err_set", 128'(slot_err), 128'd1);
    pop_head("multihot", {12{8'h3C}}, 3'd0);
`else
    pop_head("multihot", {12{8'h3C}}, 3'd2);
`endif
    send_frame({12{8'hC3}}, 7'b0000000, FB, 1'b0, 1'b0);
    pop_head("zerohot", {12{8'hC3}}, 3'd0);
`ifdef SPI_CAP_SLOT_CHECK_EN
    pulse_ovf_clr();
    check("slot_err_clr", 128'(slot_err), 128'd0);
`endif

    // Reset mid-frame discards queued and partial frames
    send_frame(pat(32'hDEAD_0000, 0), 7'b0000001, FB, 1'b0, 1'b0);
    send_frame(pat(32'hFACE_0000, 0), 7'b0000001, 40, 1'b0, 1'b0);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("midrst_valid", 128'(frame_valid), 128'd0);
    check("midrst_data", 128'(frame_data), 128'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    send_frame(pat(32'h7777_0000, 1), 7'b1000000, FB, 1'b0, 1'b0);
    pop_head("post_rst", pat(32'h7777_0000, 1), 3'd7);
    check("post_rst_empty", 128'(frame_valid), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_spi_frame_capture

`default_nettype wire
